instr_fetch_mem: RTL

//  Parametrised, synchronous instruction memory for the pipelined MIPS core; it is the successor to the

---
 rtl/mips_pkg.sv | 18 +
 rtl/imem_ram.sv | 22 ++
 rtl/instr_fetch_mem.sv | 93 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the instruction fetch memory: fault codes, default NOP and mode states.
package mips_pkg;
  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // sll $0,$0,0
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} mode_e;

  // Misaligned takes precedence over out-of-range.
  function automatic logic [1:0] fault_code(input logic misal, input logic oor);
    if (misal)    return FAULT_MISALIGN;
    else if (oor) return FAULT_RANGE;
    else          return FAULT_OK;
  endfunction
endpackage

// File: rtl/imem_ram.sv
// DEPTH x DW instruction array: one synchronous write port, one registered read port with enable.
module imem_ram #(
  parameter int DW        = 32,
  parameter int DEPTH     = 64,
  parameter     INIT_FILE = "",
  parameter int IW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/instr_fetch_mem.sv
// Synchronous instruction memory between the PC and IF/ID: one-cycle fetch with stall, flush,
// address faults and a program-load port.
module instr_fetch_mem
  import mips_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_DEFAULT),
  parameter                      INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic [1:0]            fault
);
  localparam int IW = $clog2(DEPTH);

  mode_e                 state_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [1:0]            fault_q;
  logic [DATA_WIDTH-1:0] ram_q;

  logic [IW-1:0] rd_idx, wr_idx;
  logic          pc_misal, pc_oor, prog_oor, accept, rd_en;

  assign rd_idx   = IW'(pc_addr >> 2);
  assign wr_idx   = IW'(prog_addr >> 2);
  assign pc_misal = |pc_addr[1:0];
  assign pc_oor   = (pc_addr >> (IW + 2)) != '0;
  assign prog_oor = (prog_addr >> (IW + 2)) != '0;

  assign ready  = ~prog_we & (state_q == RUN);
  assign accept = fetch_req & ~stall & ~flush & ready;
  assign rd_en  = accept & ~pc_misal & ~pc_oor;

  imem_ram #(
    .DW(DATA_WIDTH), .DEPTH(DEPTH), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i(clock),
    .we_i(prog_we & ~prog_oor),
    .waddr_i(wr_idx),
    .wdata_i(prog_data),
    .re_i(rd_en),
    .raddr_i(rd_idx),
    .rdata_o(ram_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      pc_q    <= '0;
      fault_q <= FAULT_OK;
    end else begin
      case (state_q)
        RUN:     if (prog_we)  state_q <= LOAD;
        LOAD:    if (!prog_we) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (flush) begin
        valid_q <= 1'b0;
        fault_q <= FAULT_OK;
      end else if (!stall) begin
        if (accept) begin
          pc_q    <= pc_addr;
          valid_q <= rd_en;
          fault_q <= fault_code(pc_misal, pc_oor);
        end else begin
          valid_q <= 1'b0;
          fault_q <= FAULT_OK;
        end
      end
    end
  end

  // The read register only updates on a good accept, so it holds naturally under stall.
  assign instr       = valid_q ? ram_q : NOP_WORD;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
endmodule
